// File: rtl/mmio_console.sv
// Memory-mapped console / cycle counter / halt device on the data bus.
// Console bytes are queued in a FIFO and drained to the printer port.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_addr/req_do_write/req_do_read/req_data : snooped data bus
//   hit        : request addresses the 16-byte window (comb.)
//   rsp_valid  : registered read response valid (one cycle)
//   rsp_data   : registered read response data
//   tx_valid   : FIFO head valid
//   tx_char    : FIFO head character
//   tx_ready   : consumer takes tx_char this cycle
//   halt       : sticky halt, raised once output has drained
//   halt_code  : latched exit code
//
// Register map (offset from BASE_ADDR):
//   0x0 CYCLE   R  free-running 32-bit cycle counter
//   0x4 STATUS  R  {halt, halt_pending, overflow, full, empty, count}
//                W  any write clears overflow
//   0x8 TX_DATA W  push data[7:0] when strobe[0] set
//   0xC HALT    W  latch exit code, request halt
module mmio_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h0002_FFF0,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_do_write,
    input  logic [3:0]  req_do_read,
    input  logic [31:0] req_data,
    output logic        hit,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        tx_valid,
    output logic [7:0]  tx_char,
    input  logic        tx_ready,
    output logic        halt,
    output logic [7:0]  halt_code
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [31:0] OFF_CYCLE  = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_TX     = 32'h8;
    localparam logic [31:0] OFF_HALT   = 32'hC;

    // ------------------------------------------------------------
    // State
    // ------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_pend;
    logic             r_halt;
    logic [7:0]       r_code;
    logic [31:0]      r_cycle;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;

    // ------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------
    logic [31:0] w_off;
    logic        w_is_wr;
    logic        w_is_rd;
    logic        w_sel_cycle;
    logic        w_sel_status;
    logic        w_sel_tx;
    logic        w_sel_halt;
    logic        w_sel_any;

    // Offset from the base; an unsigned compare covers the window
    // even when the base is only word aligned.
    assign w_off = req_addr - BASE_ADDR;
    assign hit   = req_valid && (w_off < 32'd16);

    assign w_sel_cycle  = hit && (w_off == OFF_CYCLE);
    assign w_sel_status = hit && (w_off == OFF_STATUS);
    assign w_sel_tx     = hit && (w_off == OFF_TX);
    assign w_sel_halt   = hit && (w_off == OFF_HALT);
    assign w_sel_any    = w_sel_cycle | w_sel_status
                        | w_sel_tx | w_sel_halt;

    // Any write strobe makes it a write; reads need a read strobe.
    assign w_is_wr = |req_do_write;
    assign w_is_rd = !w_is_wr && (|req_do_read);

    // ------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_pop      = !w_empty && tx_ready;
    assign w_push_req = w_sel_tx && w_is_wr && req_do_write[0];
    // A full FIFO still accepts a byte when the head leaves this cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is not reset: tx_char is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= req_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    assign tx_valid = !w_empty;
    assign tx_char  = w_empty ? 8'h00 : r_mem[r_rptr];

    // ------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------
    logic w_status_wr;
    assign w_status_wr = w_sel_status && w_is_wr;

    // A drop in the clearing cycle wins, so no lost byte goes unseen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_status_wr) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------
    // Halt
    // ------------------------------------------------------------
    logic w_halt_wr;
    assign w_halt_wr = w_sel_halt && w_is_wr;

    // Halt rises once the FIFO will be empty after this edge, so the
    // last character is out the cycle before halt is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
            r_halt <= 1'b0;
            r_code <= 8'h00;
        end else begin
            if (w_halt_wr) begin
                r_pend <= 1'b1;
            end
            if (w_halt_wr && !r_halt) begin
                r_code <= req_data[7:0];
            end
            if (r_pend && (w_count_nxt == '0)) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign halt      = r_halt;
    assign halt_code = r_code;

    // ------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // ------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_rd;

    always_comb begin
        w_status              = '0;
        w_status[CNT_W-1:0]   = r_count;
        w_status[8]           = w_empty;
        w_status[9]           = w_full;
        w_status[10]          = r_ovf;
        w_status[11]          = r_pend;
        w_status[12]          = r_halt;
    end

    // Write-only registers still answer reads (with zero) so a stray
    // load never leaves the core waiting.
    assign w_rd = w_sel_any && w_is_rd;

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_sel_cycle:  w_rdata = r_cycle;
            w_sel_status: w_rdata = w_status;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rd;
            if (w_rd) begin
                r_rsp_data <= w_rdata;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    // Only the low byte of write data is architecturally used.
    logic w_unused;
    assign w_unused = &{1'b0, req_data[31:8]};

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console.
// One task per scenario, each with inline comparisons.
module tb_mmio_console;

    localparam logic [31:0] A_CYC = 32'h0002_FFF0;
    localparam logic [31:0] A_STS = 32'h0002_FFF4;
    localparam logic [31:0] A_TX  = 32'h0002_FFF8;
    localparam logic [31:0] A_HLT = 32'h0002_FFFC;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_do_write;
    logic [3:0]  req_do_read;
    logic [31:0] req_data;
    logic        hit;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tx_valid;
    logic [7:0]  tx_char;
    logic        tx_ready;
    logic        halt;
    logic [7:0]  halt_code;

    int n_chk;
    int n_fail;

    mmio_console dut (
        .clk          (clk),
        .reset        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_do_write (req_do_write),
        .req_do_read  (req_do_read),
        .req_data     (req_data),
        .hit          (hit),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .tx_valid     (tx_valid),
        .tx_char      (tx_char),
        .tx_ready     (tx_ready),
        .halt         (halt),
        .halt_code    (halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        req_do_write = 4'h0;
        req_do_read  = 4'h0;
        req_data     = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s);
        req_valid    = 1'b1;
        req_addr     = a;
        req_data     = d;
        req_do_write = s;
        req_do_read  = 4'h0;
        tick();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        req_valid    = 1'b1;
        req_addr     = a;
        req_do_write = 4'h0;
        req_do_read  = 4'hF;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        #3;
        n_chk++;
        if ({tx_valid, tx_char} !== 9'h000) begin
            n_fail++;
            $display("FAIL rst_tx: got %b/%h want 0/00", tx_valid, tx_char);
        end
        n_chk++;
        if ({halt, halt_code} !== 9'h000) begin
            n_fail++;
            $display("FAIL rst_halt: got %b/%h want 0/00", halt, halt_code);
        end
        n_chk++;
        if ({rsp_valid, rsp_data} !== 33'h0) begin
            n_fail++;
            $display("FAIL rst_rsp: got %b/%h want 0/0", rsp_valid, rsp_data);
        end
        req_valid = 1'b1;
        req_addr  = A_TX;
        #1;
        n_chk++;
        if (hit !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hit: got %b want 1", hit);
        end
        req_addr = 32'h0002_0000;
        #1;
        n_chk++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_hit: got %b want 0", hit);
        end
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_hello();
        do_reset();
        tx_ready = 1'b1;
        wr(A_TX, 32'h48, 4'h1);
        n_chk++;
        if ({tx_valid, tx_char} !== {1'b1, 8'h48}) begin
            n_fail++;
            $display("FAIL hello_H: got %b/%h want 1/48", tx_valid, tx_char);
        end
        wr(A_TX, 32'h69, 4'h1);
        n_chk++;
        if ({tx_valid, tx_char} !== {1'b1, 8'h69}) begin
            n_fail++;
            $display("FAIL hello_i: got %b/%h want 1/69", tx_valid, tx_char);
        end
        tick();
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hello_empty: got %b want 0", tx_valid);
        end
        wr(A_TX, 32'h5A, 4'h2);
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe0: got %b want 0", tx_valid);
        end
        rd(A_STS);
        n_chk++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL hello_sts: got %b/%h want 1/100", rsp_valid, rsp_data);
        end
        tick();
        n_chk++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_once: got %b want 0", rsp_valid);
        end
        rd(32'h0002_0000);
        n_chk++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_rsp: got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) wr(A_TX, 32'h30 + i, 4'h1);
        rd(A_STS);
        n_chk++;
        if (rsp_data !== 32'h208) begin
            n_fail++;
            $display("FAIL ovf_full: got %h want 208", rsp_data);
        end
        wr(A_TX, 32'h38, 4'h1);
        rd(A_STS);
        n_chk++;
        if (rsp_data !== 32'h608) begin
            n_fail++;
            $display("FAIL ovf_set: got %h want 608", rsp_data);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 8'h30 + 8'(i);
            n_chk++;
            if ({tx_valid, tx_char} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got %b/%h want 1/%h",
                         i, tx_valid, tx_char, exp);
            end
            tick();
        end
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_no38: got %b/%h want 0", tx_valid, tx_char);
        end
        wr(A_STS, 32'h0, 4'hF);
        rd(A_STS);
        n_chk++;
        if (rsp_data !== 32'h100) begin
            n_fail++;
            $display("FAIL ovf_clr: got %h want 100", rsp_data);
        end
    endtask

    task automatic test_full_pop_push();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) wr(A_TX, 32'h50 + i, 4'h1);
        tx_ready = 1'b1;
        wr(A_TX, 32'h41, 4'h1);
        tx_ready = 1'b0;
        rd(A_STS);
        n_chk++;
        if (rsp_data !== 32'h208) begin
            n_fail++;
            $display("FAIL fpp_sts: got %h want 208", rsp_data);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 8'h41 : 8'h51 + 8'(i);
            n_chk++;
            if ({tx_valid, tx_char} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL fpp_drain%0d: got %b/%h want 1/%h",
                         i, tx_valid, tx_char, exp);
            end
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 3; i++) wr(A_TX, 32'h61 + i, 4'h1);
        wr(A_HLT, 32'h2A, 4'hF);
        tick();
        tick();
        n_chk++;
        if (halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_defer: got %b want 0", halt);
        end
        rd(A_STS);
        n_chk++;
        if (rsp_data !== 32'h803) begin
            n_fail++;
            $display("FAIL halt_sts: got %h want 803", rsp_data);
        end
        tx_ready = 1'b1;
        tick();
        tick();
        n_chk++;
        if (halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_early: got %b want 0", halt);
        end
        tick();
        n_chk++;
        if ({halt, halt_code} !== {1'b1, 8'h2A}) begin
            n_fail++;
            $display("FAIL halt_set: got %b/%h want 1/2a", halt, halt_code);
        end
        repeat (5) tick();
        n_chk++;
        if (halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_sticky: got %b want 1", halt);
        end
    endtask

    task automatic test_halt_empty();
        do_reset();
        wr(A_HLT, 32'h07, 4'h4);
        n_chk++;
        if (halt !== 1'b0) begin
            n_fail++;
            $display("FAIL hemp_n1: got %b want 0", halt);
        end
        tick();
        n_chk++;
        if ({halt, halt_code} !== {1'b1, 8'h07}) begin
            n_fail++;
            $display("FAIL hemp_n2: got %b/%h want 1/07", halt, halt_code);
        end
        do_reset();
        wr(A_TX, 32'h71, 4'h1);
        wr(A_HLT, 32'h11, 4'h1);
        wr(A_HLT, 32'h22, 4'h1);
        tx_ready = 1'b1;
        tick();
        n_chk++;
        if ({halt, halt_code} !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL halt_ovr: got %b/%h want 1/22", halt, halt_code);
        end
    endtask

    task automatic test_cycle();
        do_reset();
        repeat (5) tick();
        req_valid   = 1'b1;
        req_addr    = A_CYC;
        req_do_read = 4'hF;
        tick();
        n_chk++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'd5}) begin
            n_fail++;
            $display("FAIL cyc5: got %b/%0d want 1/5", rsp_valid, rsp_data);
        end
        tick();
        n_chk++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'd6}) begin
            n_fail++;
            $display("FAIL cyc6: got %b/%0d want 1/6", rsp_valid, rsp_data);
        end
        idle();
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle;
        rd(A_CYC);
        n_chk++;
        if (rsp_data !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL cyc_max: got %h want ffffffff", rsp_data);
        end
        rd(A_CYC);
        n_chk++;
        if (rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL cyc_wrap: got %h want 0", rsp_data);
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        do_reset();
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h41 + i, 4'h1);
        wr(A_HLT, 32'h33, 4'hF);
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({tx_valid, halt} !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_out: got %b/%b want 0/0", tx_valid, halt);
        end
        n_chk++;
        if (dut.r_count !== '0) begin
            n_fail++;
            $display("FAIL arst_cnt: got %0d want 0", dut.r_count);
        end
        tick();
        rst_n = 1'b1;
        rd(A_STS);
        n_chk++;
        if (rsp_data !== 32'h100) begin
            n_fail++;
            $display("FAIL arst_sts: got %h want 100", rsp_data);
        end
        tx_ready = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_valid !== 1'b0 || halt !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_stale: got %b want 0", seen);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        tx_ready = 1'b0;
        idle();
        test_reset();
        test_hello();
        test_overflow();
        test_full_pop_push();
        test_halt();
        test_halt_empty();
        test_cycle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
